uart_prog_loader: RTL



---
 rtl/uart_prog_loader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// Byte-stream program loader: parses LOAD/RUN commands from a UART receiver,
// assembles little-endian 32-bit words and writes them through a valid/ready port.
module uart_prog_loader #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter bit          HOLD_AT_RESET  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [31:0]           mem_wr_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  load_done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0]      TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [7:0]            CMD_LOAD  = 8'hA5;
    localparam logic [7:0]            CMD_RUN   = 8'h5A;

    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, WRITE} state_t;

    state_t                  state, state_n;
    logic [15:0]             count, count_n;
    logic [1:0]              byte_idx, byte_idx_n;
    logic [31:0]             word, word_n;
    logic [TMO_W-1:0]        tmo_cnt, tmo_cnt_n;
    logic                    overrun, overrun_n;
    logic                    mem_wr_valid_n;
    logic [ADDR_WIDTH-1:0]   mem_wr_addr_n;
    logic [31:0]             mem_wr_data_n;
    logic                    cpu_hold_n, busy_n, load_done_n, error_n;
    logic [15:0]             words_loaded_n;
    logic                    tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_LIMIT);

    // Next-state and next-register values
    always_comb begin
        state_n        = state;
        count_n        = count;
        byte_idx_n     = byte_idx;
        word_n         = word;
        overrun_n      = overrun;
        mem_wr_valid_n = mem_wr_valid;
        mem_wr_addr_n  = mem_wr_addr;
        mem_wr_data_n  = mem_wr_data;
        cpu_hold_n     = cpu_hold;
        load_done_n    = 1'b0;
        error_n        = error;
        words_loaded_n = words_loaded;
        tmo_cnt_n      = '0;

        case (state)
            IDLE: begin
                if (rx_valid && rx_byte == CMD_LOAD) begin
                    state_n        = CNT_LO;
                    cpu_hold_n     = 1'b1;
                    error_n        = 1'b0;
                    words_loaded_n = '0;
                    mem_wr_addr_n  = BASE;
                end else if (rx_valid && rx_byte == CMD_RUN) begin
                    cpu_hold_n = 1'b0;
                end
            end
            CNT_LO: begin
                if (rx_valid) begin
                    count_n[7:0] = rx_byte;
                    state_n      = CNT_HI;
                end else if (tmo_hit) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end
            end
            CNT_HI: begin
                if (rx_valid) begin
                    count_n[15:8] = rx_byte;
                    byte_idx_n    = '0;
                    if ({rx_byte, count[7:0]} == 16'd0) begin
                        state_n     = IDLE;
                        load_done_n = 1'b1;
                    end else begin
                        state_n = DATA;
                    end
                end else if (tmo_hit) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    byte_idx_n = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        mem_wr_data_n  = {rx_byte, word[23:0]};
                        mem_wr_valid_n = 1'b1;
                        overrun_n      = 1'b0;
                        state_n        = WRITE;
                    end else begin
                        word_n[8*byte_idx +: 8] = rx_byte;
                    end
                end else if (tmo_hit) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end
            end
            WRITE: begin
                // Bytes arriving while a write is pending cannot be stored: abort after the write.
                if (rx_valid) begin
                    error_n   = 1'b1;
                    overrun_n = 1'b1;
                end
                if (mem_wr_ready) begin
                    mem_wr_valid_n = 1'b0;
                    mem_wr_addr_n  = mem_wr_addr + ADDR_WIDTH'(4);
                    words_loaded_n = words_loaded + 16'd1;
                    if (overrun || rx_valid) begin
                        state_n = IDLE;
                    end else if (words_loaded + 16'd1 == count) begin
                        state_n     = IDLE;
                        load_done_n = 1'b1;
                    end else begin
                        state_n = DATA;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Inter-byte timer: cleared on bytes and state changes, runs only while awaiting bytes
        if (!rx_valid && state_n == state &&
            (state == CNT_LO || state == CNT_HI || state == DATA)) begin
            tmo_cnt_n = tmo_cnt + TMO_W'(1);
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            byte_idx     <= '0;
            word         <= '0;
            tmo_cnt      <= '0;
            overrun      <= 1'b0;
            mem_wr_valid <= 1'b0;
            mem_wr_addr  <= BASE;
            mem_wr_data  <= '0;
            cpu_hold     <= HOLD_AT_RESET;
            busy         <= 1'b0;
            load_done    <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            byte_idx     <= byte_idx_n;
            word         <= word_n;
            tmo_cnt      <= tmo_cnt_n;
            overrun      <= overrun_n;
            mem_wr_valid <= mem_wr_valid_n;
            mem_wr_addr  <= mem_wr_addr_n;
            mem_wr_data  <= mem_wr_data_n;
            cpu_hold     <= cpu_hold_n;
            busy         <= busy_n;
            load_done    <= load_done_n;
            error        <= error_n;
            words_loaded <= words_loaded_n;
        end
    end

endmodule
